// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for fifo_wr_arbiter.
// The slave side is the arbiter; the master side drives requests and full.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_wr_en;
  logic                  fifo_full;

  modport master (
    output req_data,
    output req_valid,
    output fifo_full,
    input  req_ready,
    input  grant,
    input  fifo_din,
    input  fifo_wr_en
  );

  modport slave (
    input  req_data,
    input  req_valid,
    input  fifo_full,
    output req_ready,
    output grant,
    output fifo_din,
    output fifo_wr_en
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NREQ requesters onto one FIFO
// write port; grants last up to BURST beats, then a one-cycle bubble.
module fifo_wr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic CLK,
  input  logic RST,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NR = (IW+1)'(NREQ);
  localparam logic [3:0] LAST = 4'(BURST-1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   ptr;
  logic [3:0]      cnt;

  logic [IW-1:0]   sel;
  logic [IW-1:0]   nxt;
  logic [IW:0]     idx;
  logic            found;
  logic            beat;
  logic            rel;

  // first valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  assign beat = (state == GRANT)
             && bus.req_valid[gidx]
             && !bus.fifo_full;

  assign rel = (state == GRANT)
            && ((beat && cnt == LAST)
             || !bus.req_valid[gidx]);

  assign nxt = (({1'b0, gidx} + 1'b1) == NR)
             ? '0 : gidx + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      grant_q <= '0;
      gidx    <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            grant_q <= ONE << sel;
            gidx    <= sel;
            cnt     <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= nxt;
            cnt     <= '0;
          end else if (beat) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.fifo_wr_en = beat;

  always_comb begin
    bus.req_ready = '0;
    bus.fifo_din  = '0;
    if (beat) bus.req_ready[gidx] = 1'b1;
    if (state == GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gidx == IW'(i))
          bus.fifo_din = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (BURST=4 and BURST=1).
// Both instances see the same stimulus; each vector names the one it checks.
module tb_fifo_wr_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0]   valid = '0;
  logic           full  = 1'b0;
  logic [N*W-1:0] data  = '0;

  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) b4 ();
  fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) b1 ();

  assign b4.req_valid = valid;
  assign b4.req_data  = data;
  assign b4.fifo_full = full;
  assign b1.req_valid = valid;
  assign b1.req_data  = data;
  assign b1.fifo_full = full;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b4.slave)
  );

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (b1.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          tag;
    bit             rst;
    bit             use1;
    logic [N-1:0]   v;
    logic           f;
    logic [N*W-1:0] d;
    logic [N-1:0]   g;
    logic           wr;
    logic [N-1:0]   rdy;
    logic [W-1:0]   din;
    bit             ckptr;
    logic [1:0]     ptr;
  } vec_t;

  vec_t vq[$];

  localparam logic [N*W-1:0] DALL =
    {16'h4D33, 16'h3C22, 16'h2B11, 16'h1A00};

  function automatic logic [W-1:0] dw(int i);
    case (i)
      0:       return 16'h1A00;
      1:       return 16'h2B11;
      2:       return 16'h3C22;
      default: return 16'h4D33;
    endcase
  endfunction

  function automatic logic [W-1:0] w2(int k);
    return 16'hC000 + 16'(k);
  endfunction

  function automatic logic [N*W-1:0] d2(int k);
    return {16'h0, w2(k), 16'h0, 16'h0};
  endfunction

  function automatic void add(
    string t, bit r, bit u, logic [N-1:0] v, logic f,
    logic [N*W-1:0] d, logic [N-1:0] g, logic wr,
    logic [N-1:0] rdy, logic [W-1:0] din,
    bit cp = 0, logic [1:0] p = '0);
    vec_t x;
    x.tag = t; x.rst = r; x.use1 = u;
    x.v = v; x.f = f; x.d = d;
    x.g = g; x.wr = wr; x.rdy = rdy; x.din = din;
    x.ckptr = cp; x.ptr = p;
    vq.push_back(x);
  endfunction

  task automatic chk(string nm, int c, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, c, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    valid = '0;
    full = 1'b0;
    data = '0;
    #1;
    chk("rst_grant", 0, 64'(b4.grant), 64'h0);
    chk("rst_wr", 0, 64'(b4.fifo_wr_en), 64'h0);
    chk("rst_rdy", 0, 64'(b4.req_ready), 64'h0);
    chk("rst_din", 0, 64'(b4.fifo_din), 64'h0);
    chk("rst_ptr", 0, 64'(dut.ptr), 64'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    // all four requesters streaming: 0,1,2,3,0 with 4 beats each
    for (int c = 0; c < 22; c++) begin
      if (c % 5 == 0)
        add("rr4", c == 0, 0, 4'hF, 0, DALL,
            4'h0, 0, 4'h0, 16'h0);
      else begin
        int gi;
        gi = ((c - 1) / 5) % 4;
        add("rr4", 0, 0, 4'hF, 0, DALL,
            4'(1 << gi), 1, 4'(1 << gi), dw(gi));
      end
    end

    // requester 2 alone with ten words: bursts 4,4,2
    add("solo", 1, 0, 4'h4, 0, d2(0), 4'h0, 0, 4'h0, 16'h0);
    for (int k = 0; k < 4; k++)
      add("solo", 0, 0, 4'h4, 0, d2(k), 4'h4, 1, 4'h4, w2(k));
    add("solo", 0, 0, 4'h4, 0, d2(4), 4'h0, 0, 4'h0, 16'h0,
        1, 2'd3);
    for (int k = 4; k < 8; k++)
      add("solo", 0, 0, 4'h4, 0, d2(k), 4'h4, 1, 4'h4, w2(k));
    add("solo", 0, 0, 4'h4, 0, d2(8), 4'h0, 0, 4'h0, 16'h0,
        1, 2'd3);
    for (int k = 8; k < 10; k++)
      add("solo", 0, 0, 4'h4, 0, d2(k), 4'h4, 1, 4'h4, w2(k));
    add("solo", 0, 0, 4'h0, 0, '0, 4'h4, 0, 4'h0, 16'h0);
    add("solo", 0, 0, 4'h0, 0, '0, 4'h0, 0, 4'h0, 16'h0,
        1, 2'd3);

    // requester 1 stalled by full for 5 cycles after beat 2
    add("full", 1, 0, 4'h2, 0, DALL, 4'h0, 0, 4'h0, 16'h0);
    for (int c = 0; c < 2; c++)
      add("full", 0, 0, 4'h2, 0, DALL, 4'h2, 1, 4'h2, dw(1));
    for (int c = 0; c < 5; c++)
      add("full", 0, 0, 4'h2, 1, DALL, 4'h2, 0, 4'h0, dw(1));
    for (int c = 0; c < 2; c++)
      add("full", 0, 0, 4'h2, 0, DALL, 4'h2, 1, 4'h2, dw(1));
    add("full", 0, 0, 4'h2, 0, DALL, 4'h0, 0, 4'h0, 16'h0,
        1, 2'd2);

    // requester 0 drops after one beat; requester 3 waiting
    add("drop", 1, 0, 4'h9, 0, DALL, 4'h0, 0, 4'h0, 16'h0);
    add("drop", 0, 0, 4'h9, 0, DALL, 4'h1, 1, 4'h1, dw(0));
    add("drop", 0, 0, 4'h8, 0, DALL, 4'h1, 0, 4'h0, dw(0));
    add("drop", 0, 0, 4'h8, 0, DALL, 4'h0, 0, 4'h0, 16'h0,
        1, 2'd1);
    add("drop", 0, 0, 4'h8, 0, DALL, 4'h8, 1, 4'h8, dw(3));

    // BURST=1: requesters 1 and 3 alternate single words
    add("b1", 1, 1, 4'hA, 0, DALL, 4'h0, 0, 4'h0, 16'h0);
    for (int r = 0; r < 2; r++) begin
      add("b1", 0, 1, 4'hA, 0, DALL, 4'h2, 1, 4'h2, dw(1));
      add("b1", 0, 1, 4'hA, 0, DALL, 4'h0, 0, 4'h0, 16'h0);
      add("b1", 0, 1, 4'hA, 0, DALL, 4'h8, 1, 4'h8, dw(3));
      add("b1", 0, 1, 4'hA, 0, DALL, 4'h0, 0, 4'h0, 16'h0);
    end
    add("b1", 0, 1, 4'hA, 1, DALL, 4'h2, 0, 4'h0, dw(1));
    add("b1", 0, 1, 4'hA, 0, DALL, 4'h2, 1, 4'h2, dw(1));

    foreach (vq[k]) begin
      if (vq[k].rst) do_reset();
      valid = vq[k].v;
      full  = vq[k].f;
      data  = vq[k].d;
      #1;
      if (vq[k].use1) begin
        chk({vq[k].tag, "_grant"}, k, 64'(b1.grant), 64'(vq[k].g));
        chk({vq[k].tag, "_wr"}, k, 64'(b1.fifo_wr_en),
            64'(vq[k].wr));
        chk({vq[k].tag, "_rdy"}, k, 64'(b1.req_ready),
            64'(vq[k].rdy));
        chk({vq[k].tag, "_din"}, k, 64'(b1.fifo_din),
            64'(vq[k].din));
      end else begin
        chk({vq[k].tag, "_grant"}, k, 64'(b4.grant), 64'(vq[k].g));
        chk({vq[k].tag, "_wr"}, k, 64'(b4.fifo_wr_en),
            64'(vq[k].wr));
        chk({vq[k].tag, "_rdy"}, k, 64'(b4.req_ready),
            64'(vq[k].rdy));
        chk({vq[k].tag, "_din"}, k, 64'(b4.fifo_din),
            64'(vq[k].din));
      end
      if (vq[k].ckptr)
        chk({vq[k].tag, "_ptr"}, k, 64'(dut.ptr), 64'(vq[k].ptr));
      @(posedge CLK);
      #1;
    end

    // reset pulsed mid-burst of requester 2
    do_reset();
    valid = 4'h4;
    data  = DALL;
    #1;
    chk("mrst_idle", 0, 64'(b4.grant), 64'h0);
    @(posedge CLK); #1;
    chk("mrst_b1", 1, 64'(b4.fifo_wr_en), 64'h1);
    @(posedge CLK); #1;
    chk("mrst_b2", 2, 64'(b4.grant), 64'h4);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("mrst_grant", 3, 64'(b4.grant), 64'h0);
    chk("mrst_wr", 3, 64'(b4.fifo_wr_en), 64'h0);
    chk("mrst_din", 3, 64'(b4.fifo_din), 64'h0);
    chk("mrst_rdy", 3, 64'(b4.req_ready), 64'h0);
    valid = 4'h6;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("mrst_rel_wr", 4, 64'(b4.fifo_wr_en), 64'h0);
    chk("mrst_rel_g", 4, 64'(b4.grant), 64'h0);
    @(posedge CLK); #1;
    chk("mrst_first_g", 5, 64'(b4.grant), 64'h2);
    chk("mrst_first_d", 5, 64'(b4.fifo_din), 64'(dw(1)));
    chk("mrst_first_wr", 5, 64'(b4.fifo_wr_en), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
